// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle MIPS-I datapath: opcode and funct
// constants, the 3-bit ALU control encoding, the FSM state enum and the
// funct decode helpers.
package mc_pkg;

  localparam int unsigned REG_COUNT = 32;
  localparam int unsigned REG_AW    = 5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_ctl_t;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXEC, ALUWB, BRANCH, ADDIWB, JUMP, TRAP
  } state_t;

  function automatic logic funct_valid(input logic [5:0] funct);
    return funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
  endfunction

  function automatic alu_ctl_t funct_to_alu(input logic [5:0] funct);
    case (funct)
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mc_datapath_regfile.sv
// 32 x XLEN register file: two asynchronous read ports, one synchronous
// write port. Register 0 reads as zero and ignores writes. No reset.
//   clk      - write clock
//   we/wa/wd - write enable, address, data
//   ra1/rd1  - read port 1 address/data
//   ra2/rd2  - read port 2 address/data
module regfile
  import mc_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [REG_AW-1:0] wa,
  input  logic [XLEN-1:0]   wd,
  input  logic [REG_AW-1:0] ra1,
  output logic [XLEN-1:0]   rd1,
  input  logic [REG_AW-1:0] ra2,
  output logic [XLEN-1:0]   rd2
);

  logic [XLEN-1:0] regs [REG_COUNT];

  always_ff @(posedge clk) begin
    if (we && (wa != '0)) regs[wa] <= wd;
  end

  assign rd1 = (ra1 == '0) ? '0 : regs[ra1];
  assign rd2 = (ra2 == '0) ? '0 : regs[ra2];

endmodule

// File: rtl/mc_datapath.sv
// Multicycle MIPS-I subset core (lw, sw, add, sub, and, or, slt, beq, addi, j)
// over a single shared instruction/data memory port.
//   clk                 - clock, rising edge
//   reset               - asynchronous active-low reset
//   mem_req/mem_we      - transfer request / write select
//   mem_addr/mem_wdata  - byte address / store data, held while pending
//   mem_ready/mem_rdata - transfer completion / read data
//   pc                  - program counter
//   retire              - one-cycle pulse in each instruction's final state
//   illegal             - sticky trap flag, cleared only by reset
module mc_datapath
  import mc_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter bit              JUMP_EN  = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [XLEN-1:0] pc,
  output logic            retire,
  output logic            illegal
);

  state_t          state;
  state_t          dec_next;
  logic [31:0]     ir;
  logic [XLEN-1:0] a, b, alu_out, mdr;
  logic [XLEN-1:0] imm_sext, alu_result, jump_target;
  logic [XLEN-1:0] rf_rd1, rf_rd2, rf_wd;
  logic [REG_AW-1:0] rf_wa;
  logic            rf_we;
  logic            retire_q;
  alu_ctl_t        alu_ctl;

  logic [5:0] opcode, funct;
  assign opcode = ir[31:26];
  assign funct  = ir[5:0];

  assign imm_sext    = {{(XLEN-16){ir[15]}}, ir[15:0]};
  assign jump_target = {pc[XLEN-1:28], ir[25:0], 2'b00};
  assign alu_ctl     = funct_to_alu(funct);

  // Address and store data come straight from registers that only change
  // when a transfer completes, so they stay stable across wait cycles.
  assign mem_addr  = (state == FETCH) ? pc : alu_out;
  assign mem_wdata = b;

  // A store's final cycle is the one where its write completes, which is
  // only known from mem_ready in that cycle.
  assign retire = retire_q | ((state == MEMWR) & mem_req & mem_ready);

  regfile #(.XLEN(XLEN)) u_rf (
    .clk (clk),
    .we  (rf_we),
    .wa  (rf_wa),
    .wd  (rf_wd),
    .ra1 (ir[25:21]),
    .rd1 (rf_rd1),
    .ra2 (ir[20:16]),
    .rd2 (rf_rd2)
  );

  always_comb begin
    rf_we = 1'b0;
    rf_wa = ir[20:16];
    rf_wd = alu_out;
    case (state)
      MEMWB:  begin rf_we = 1'b1; rf_wd = mdr; end
      ADDIWB: rf_we = 1'b1;
      ALUWB:  begin rf_we = 1'b1; rf_wa = ir[15:11]; end
      default: ;
    endcase
  end

  always_comb begin
    alu_result = '0;
    case (alu_ctl)
      ALU_AND: alu_result = a & b;
      ALU_OR:  alu_result = a | b;
      ALU_ADD: alu_result = a + b;
      ALU_SUB: alu_result = a - b;
      ALU_SLT: alu_result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      default: alu_result = '0;
    endcase
  end

  always_comb begin
    dec_next = TRAP;
    case (opcode)
      OP_LW, OP_SW, OP_ADDI: dec_next = MEMADR;
      OP_RTYPE:              dec_next = funct_valid(funct) ? EXEC : TRAP;
      OP_BEQ:                dec_next = BRANCH;
      OP_J:                  dec_next = JUMP_EN ? JUMP : TRAP;
      default:               dec_next = TRAP;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      ir       <= '0;
      a        <= '0;
      b        <= '0;
      alu_out  <= '0;
      mdr      <= '0;
      illegal  <= 1'b0;
      retire_q <= 1'b0;
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
    end else begin
      retire_q <= 1'b0;
      case (state)
        // After reset FETCH is entered with mem_req low; the first edge
        // raises it. Every other entry into FETCH raises it on the way in.
        FETCH: begin
          mem_we <= 1'b0;
          if (mem_req && mem_ready) begin
            ir      <= mem_rdata[31:0];
            pc      <= pc + XLEN'(4);
            mem_req <= 1'b0;
            state   <= DECODE;
          end else begin
            mem_req <= 1'b1;
          end
        end
        DECODE: begin
          a       <= rf_rd1;
          b       <= rf_rd2;
          alu_out <= pc + (imm_sext << 2);
          state   <= dec_next;
          if (dec_next == TRAP) illegal <= 1'b1;
          if (dec_next == BRANCH || dec_next == JUMP) retire_q <= 1'b1;
        end
        MEMADR: begin
          alu_out <= a + imm_sext;
          case (opcode)
            OP_LW: begin state <= MEMRD; mem_req <= 1'b1; mem_we <= 1'b0; end
            OP_SW: begin state <= MEMWR; mem_req <= 1'b1; mem_we <= 1'b1; end
            default: begin state <= ADDIWB; retire_q <= 1'b1; end
          endcase
        end
        MEMRD: begin
          if (mem_ready) begin
            mdr      <= mem_rdata;
            mem_req  <= 1'b0;
            retire_q <= 1'b1;
            state    <= MEMWB;
          end
        end
        MEMWR: begin
          if (mem_ready) begin
            mem_req <= 1'b1;
            mem_we  <= 1'b0;
            state   <= FETCH;
          end
        end
        EXEC: begin
          alu_out  <= alu_result;
          retire_q <= 1'b1;
          state    <= ALUWB;
        end
        BRANCH: begin
          if (a == b) pc <= alu_out;
          mem_req <= 1'b1;
          state   <= FETCH;
        end
        JUMP: begin
          pc      <= jump_target;
          mem_req <= 1'b1;
          state   <= FETCH;
        end
        MEMWB, ALUWB, ADDIWB: begin
          mem_req <= 1'b1;
          state   <= FETCH;
        end
        TRAP: begin
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
        end
        default: state <= TRAP;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_datapath.sv
module tb_mc_datapath;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            mem_req, mem_we, retire, illegal;
  logic [XLEN-1:0] mem_addr, mem_wdata, pc;
  logic            mem_ready = 1'b0;
  logic [XLEN-1:0] mem_rdata = '0;

  logic [31:0] mem [256];
  int          delay = 0;
  int          wcnt = 0;
  int          stab_err = 0;
  int          wr_cnt = 0;
  logic [31:0] last_waddr = '0, last_wdata = '0;
  logic [31:0] cap_addr = '0, cap_wdata = '0;
  logic        cap_we = 1'b0;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  int rcount = 0;
  int ret_cyc [32];
  int bad;

  mc_datapath #(.XLEN(XLEN), .RESET_PC(32'h0), .JUMP_EN(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .pc        (pc),
    .retire    (retire),
    .illegal   (illegal)
  );

  initial forever #5 clk = ~clk;

  // Memory responder: 'delay' wait cycles per transfer, then one ready cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (mem_req !== 1'b1) begin
        mem_ready = 1'b0;
        wcnt = 0;
      end else begin
        if (mem_ready) wcnt = 0;
        if (wcnt == 0) begin
          cap_addr = mem_addr; cap_wdata = mem_wdata; cap_we = mem_we;
        end else if (mem_addr !== cap_addr || mem_wdata !== cap_wdata || mem_we !== cap_we) begin
          stab_err++;
        end
        if (wcnt >= delay) begin
          mem_ready = 1'b1;
          mem_rdata = mem[mem_addr[9:2]];
          if (mem_we) begin
            mem[mem_addr[9:2]] = mem_wdata;
            wr_cnt++;
            last_waddr = mem_addr;
            last_wdata = mem_wdata;
          end
        end else begin
          mem_ready = 1'b0;
          wcnt++;
        end
      end
    end
  end

  function automatic logic [31:0] i_addi(int rt, int rs, int imm);
    return {6'h08, 5'(rs), 5'(rt), 16'(imm)};
  endfunction
  function automatic logic [31:0] i_lw(int rt, int base, int off);
    return {6'h23, 5'(base), 5'(rt), 16'(off)};
  endfunction
  function automatic logic [31:0] i_sw(int rt, int base, int off);
    return {6'h2B, 5'(base), 5'(rt), 16'(off)};
  endfunction
  function automatic logic [31:0] i_beq(int rs, int rt, int off);
    return {6'h04, 5'(rs), 5'(rt), 16'(off)};
  endfunction
  function automatic logic [31:0] i_r(int rd, int rs, int rt, int fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h0, 6'(fn)};
  endfunction
  function automatic logic [31:0] i_j(int idx);
    return {6'h02, 26'(idx)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = '0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b1;
    cyc = 0;
    rcount = 0;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    release_reset();
  endtask

  // One clock cycle; sampling happens in the second half of the cycle.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
    cyc++;
    if (retire === 1'b1) begin
      rcount++;
      if (rcount < 32) ret_cyc[rcount] = cyc;
    end
  endtask

  task automatic run_retires(input int n, input int limit);
    while (rcount < n && cyc < limit) step();
    chk("retire_budget", rcount, n);
  endtask

  initial begin
    // Reset state
    clear_mem();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_req", {31'b0, mem_req}, 32'd0);
    chk("rst_we", {31'b0, mem_we}, 32'd0);
    chk("rst_retire", {31'b0, retire}, 32'd0);
    chk("rst_illegal", {31'b0, illegal}, 32'd0);

    // addi/addi/add, zero-wait: retire at cycles 4, 8, 12
    mem[0] = i_addi(1, 0, 5);
    mem[1] = i_addi(2, 0, 7);
    mem[2] = i_r(3, 1, 2, 6'h20);
    delay = 0;
    release_reset();
    chk("first_req_c0", {31'b0, mem_req}, 32'd0);
    for (int k = 1; k <= 12; k++) begin
      step();
      chk("retire_a", {31'b0, retire}, (cyc % 4 == 0) ? 32'd1 : 32'd0);
      if (k == 1) begin
        chk("first_req_c1", {31'b0, mem_req}, 32'd1);
        chk("first_addr", mem_addr, 32'h0);
      end
    end
    chk("pc_a", pc, 32'hC);
    step();
    chk("r1", dut.u_rf.regs[1], 32'd5);
    chk("r2", dut.u_rf.regs[2], 32'd7);
    chk("r3", dut.u_rf.regs[3], 32'd12);

    // sw/lw with 3 wait cycles per transfer
    clear_mem();
    mem[0] = i_addi(3, 0, 12);
    mem[1] = i_sw(3, 0, 32'h40);
    mem[2] = i_lw(4, 0, 32'h40);
    delay = 3;
    stab_err = 0;
    wr_cnt = 0;
    do_reset();
    run_retires(3, 100);
    chk("cyc_addi_w", ret_cyc[1], 32'd7);
    chk("cyc_sw_w", ret_cyc[2], 32'd17);
    chk("cyc_lw_w", ret_cyc[3], 32'd28);
    step();
    chk("waddr", last_waddr, 32'h40);
    chk("wdata", last_wdata, 32'd12);
    chk("wr_cnt", wr_cnt, 32'd1);
    chk("mem40", mem[16], 32'd12);
    chk("r4_lw", dut.u_rf.regs[4], 32'd12);
    chk("stable", stab_err, 32'd0);

    // beq taken at 0x10 back to itself, 3-cycle period
    clear_mem();
    mem[0] = i_addi(1, 0, 3);
    mem[1] = i_addi(2, 0, 3);
    mem[2] = i_addi(6, 0, 1);
    mem[3] = i_addi(6, 0, 2);
    mem[4] = i_beq(1, 2, -1);
    delay = 0;
    do_reset();
    run_retires(5, 100);
    chk("beq_cyc", ret_cyc[5], 32'd19);
    chk("beq_pc_in", pc, 32'h14);
    step();
    chk("beq_taken_pc", pc, 32'h10);
    chk("beq_taken_addr", mem_addr, 32'h10);
    chk("beq_taken_req", {31'b0, mem_req}, 32'd1);
    run_retires(6, 100);
    chk("beq_period", ret_cyc[6], 32'd22);

    // beq not taken at 0x10
    mem[1] = i_addi(2, 0, 4);
    do_reset();
    run_retires(5, 100);
    step();
    chk("beq_nt_pc", pc, 32'h14);
    chk("beq_nt_addr", mem_addr, 32'h14);

    // $0 write discarded, then j and sign-extended addi
    clear_mem();
    mem[0] = i_addi(5, 0, 33);
    mem[1] = i_addi(0, 0, 9);
    mem[2] = i_r(5, 0, 0, 6'h20);
    mem[3] = i_j(8);
    mem[8] = i_addi(7, 0, -2);
    do_reset();
    run_retires(5, 100);
    chk("j_cyc", ret_cyc[4], 32'd15);
    chk("j_pc", pc, 32'h24);
    step();
    chk("r5_zero", dut.u_rf.regs[5], 32'd0);
    chk("r7_sext", dut.u_rf.regs[7], 32'hFFFF_FFFE);

    // ALU ops: slt signed, sub, and, or
    clear_mem();
    mem[0] = i_addi(1, 0, -2);
    mem[1] = i_addi(2, 0, 5);
    mem[2] = i_r(3, 1, 2, 6'h2A);
    mem[3] = i_r(4, 2, 1, 6'h2A);
    mem[4] = i_r(5, 1, 2, 6'h22);
    mem[5] = i_r(6, 1, 2, 6'h24);
    mem[6] = i_r(7, 1, 2, 6'h25);
    do_reset();
    run_retires(7, 200);
    chk("alu_cyc", ret_cyc[7], 32'd28);
    step();
    chk("slt_lt", dut.u_rf.regs[3], 32'd1);
    chk("slt_ge", dut.u_rf.regs[4], 32'd0);
    chk("sub", dut.u_rf.regs[5], 32'hFFFF_FFF9);
    chk("and", dut.u_rf.regs[6], 32'd4);
    chk("or", dut.u_rf.regs[7], 32'hFFFF_FFFF);

    // Illegal opcode at 0x8 traps; async reset clears it
    clear_mem();
    mem[0] = i_addi(1, 0, 1);
    mem[1] = i_addi(1, 0, 2);
    mem[2] = 32'hFC00_0000;
    do_reset();
    bad = 0;
    for (int k = 0; k < 25; k++) begin
      step();
      if (cyc >= 11 && mem_req !== 1'b0) bad++;
    end
    chk("trap_illegal", {31'b0, illegal}, 32'd1);
    chk("trap_pc", pc, 32'hC);
    chk("trap_req", bad, 32'd0);
    chk("trap_retires", rcount, 32'd2);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("arst_illegal", {31'b0, illegal}, 32'd0);
    chk("arst_pc", pc, 32'h0);
    chk("arst_req", {31'b0, mem_req}, 32'd0);

    // Reset during a load's wait: request drops at once, no writeback
    clear_mem();
    mem[0] = i_addi(4, 0, 32'h55);
    mem[1] = i_lw(4, 0, 32'h40);
    mem[16] = 32'h99;
    delay = 3;
    repeat (2) @(posedge clk);
    release_reset();
    run_retires(1, 100);
    while (!(mem_req === 1'b1 && mem_addr === 32'h40) && cyc < 100) step();
    chk("lw_wait_addr", mem_addr, 32'h40);
    reset = 1'b0;
    #1;
    chk("abort_req", {31'b0, mem_req}, 32'd0);
    chk("abort_retire", {31'b0, retire}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_r4", dut.u_rf.regs[4], 32'h55);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/mc_datapath.md
MC_DATAPATH -- requirements
Module: mc_datapath

Interface
REQ-001 SHALL provide parameter XLEN, default 32, data/address width (minimum 32).
REQ-002 SHALL provide parameter RESET_PC, default 0, PC value loaded on reset.
REQ-003 SHALL provide parameter JUMP_EN, default 1; when 0, opcode j is treated as illegal.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-006 mem_req  output  1  memory transfer request.
REQ-007 mem_we  output  1  1 = write, 0 = read; valid while mem_req=1.
REQ-008 mem_addr  output  XLEN  byte address, word-aligned.
REQ-009 mem_wdata  output  XLEN  store data.
REQ-010 mem_ready  input  1  transfer completes in any cycle with mem_req=1 and mem_ready=1.
REQ-011 mem_rdata  input  XLEN  read data, valid in the completing cycle.
REQ-012 pc  output  XLEN  current program counter.
REQ-013 retire  output  1  one-cycle pulse when an instruction completes.
REQ-014 illegal  output  1  sticky trap flag.

Function
REQ-015 SHALL execute lw, sw, add, sub, and, or, slt, beq, addi and j (MIPS-I encodings) over a shared instruction/data memory.
REQ-016 SHALL use FSM states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIWB, JUMP, TRAP.
- FETCH -> DECODE.
- DECODE -> MEMADR (lw/sw/addi), EXEC (R-type), BRANCH (beq), JUMP (j), TRAP (other).
- MEMADR -> MEMRD (lw), MEMWR (sw), ADDIWB (addi).
- MEMRD -> MEMWB.
- EXEC -> ALUWB.
- MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH, JUMP -> FETCH.
REQ-017 FETCH, MEMRD and MEMWR SHALL hold mem_req=1 and stay in state until mem_ready=1.
REQ-018 mem_addr, mem_we and mem_wdata SHALL remain stable while the request is pending.
REQ-019 FETCH SHALL drive mem_addr=pc and mem_we=0; on completion it SHALL latch IR and set pc <= pc+4.
REQ-020 DECODE SHALL latch A=rs and B=rt, and SHALL compute the branch target pc + (signext(imm)<<2).
REQ-021 SHALL sign-extend the immediate from 16 bits to XLEN; all arithmetic is modulo 2^XLEN.
REQ-022 slt SHALL compare signed and produce 1 or 0.
REQ-023 BRANCH SHALL load the target into pc iff A==B.
REQ-024 JUMP SHALL load {pc[XLEN-1:28], IR[25:0], 2'b00}.
REQ-025 Cycle counts with zero-wait memory SHALL be: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3; each memory wait cycle adds 1.
REQ-026 retire SHALL pulse in the final state of each instruction.
REQ-027 Writes to register 0 SHALL be discarded; register 0 SHALL always read as 0.
REQ-028 TRAP SHALL set illegal=1, hold mem_req=0 and pc frozen, and be exited only by reset.
REQ-029 mem_req SHALL be 0 in all states other than FETCH, MEMRD and MEMWR.

Reset
REQ-030 On reset=0, asynchronously and without waiting for a clock: state=FETCH, pc=RESET_PC, IR/A/B/ALUOut=0, illegal=0, retire=0, mem_req=0, mem_we=0.
REQ-031 Reset asserted mid-transfer SHALL abandon the transfer; no register file write occurs for the aborted instruction.
REQ-032 The first mem_req after reset release SHALL be issued on the first rising edge with reset=1.
REQ-033 Register file contents SHALL NOT be reset.

Structure
REQ-034 Shared package mc_pkg SHALL hold the opcode/funct constants, the 3-bit ALU control encoding and the state enum.
REQ-035 Sub-module regfile SHALL be instantiated: 32 x XLEN, two read ports, one write port; datapath and FSM stay in mc_datapath.

Verification
REQ-036 Zero-wait memory, program addi $1,$0,5; addi $2,$0,7; add $3,$1,$2 -> $3=12, retire pulses at cycles 4, 8, 12.
REQ-037 sw $3,0x40($0) then lw $4,0x40($0) with mem_ready delayed 3 cycles per transfer -> mem write addr 0x40 data 12, $4=12, mem_addr/mem_wdata stable during waits.
REQ-038 beq $1,$1,-1 at pc 0x10 -> pc returns to 0x10 after 3 cycles; beq with unequal operands -> pc=0x14.
REQ-039 addi $0,$0,9 followed by add $5,$0,$0 -> $5=0.
REQ-040 Opcode 0x3F at pc 0x8 -> illegal=1 and mem_req=0 thereafter; reset=0 clears illegal and sets pc=RESET_PC.
REQ-041 reset pulled low during a MEMRD wait -> mem_req drops within the same cycle, target register unchanged.
